// File: rtl/cfu_if_pkg.sv
// Shared definitions for the CFU command/response interface.
// Holds the initiator state encoding, default bus widths shared with CFU
// responders, and the function_id field layout used by the PIM CFU so that
// hosts and benches can build ids without hard-coding bit positions.
package cfu_if_pkg;

    localparam int CFU_DWIDTH = 32;
    localparam int CFU_AWIDTH = 10;

    // PIM CFU function_id layout: bit0 write, bit1 process, top 8 bits address.
    localparam int FID_WRITE_BIT   = 0;
    localparam int FID_PROCESS_BIT = 1;
    localparam int FID_ADDR_W      = 8;
    localparam int FID_ADDR_LSB    = CFU_AWIDTH - FID_ADDR_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } cfu_state_e;

    function automatic logic [CFU_AWIDTH-1:0] make_function_id(
        input logic                  wr,
        input logic                  proc,
        input logic [FID_ADDR_W-1:0] addr
    );
        logic [CFU_AWIDTH-1:0] id;
        id                                          = '0;
        id[FID_WRITE_BIT]                           = wr;
        id[FID_PROCESS_BIT]                         = proc;
        id[FID_ADDR_LSB +: FID_ADDR_W]              = addr;
        return id;
    endfunction

endpackage

// File: rtl/cfu_cmd_initiator_if.sv
// CFU command/response bus.
// master modport: initiator side (drives cmd_*, rsp_ready).
// slave modport : responder side (drives cmd_ready, rsp_*).
interface cfu_cmd_initiator_if
    import cfu_if_pkg::*;
#(
    parameter int DWIDTH = CFU_DWIDTH,
    parameter int AWIDTH = CFU_AWIDTH
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWIDTH-1:0] cmd_payload_function_id;
    logic [DWIDTH-1:0] cmd_payload_inputs_0;
    logic [DWIDTH-1:0] cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_payload_response_ok;
    logic [DWIDTH-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid,
        output cmd_payload_function_id,
        output cmd_payload_inputs_0,
        output cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_payload_response_ok,
        input  rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid,
        input  cmd_payload_function_id,
        input  cmd_payload_inputs_0,
        input  cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready,
        output rsp_valid,
        output rsp_payload_response_ok,
        output rsp_payload_outputs_0
    );

endinterface

// File: rtl/cfu_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (sync, active-high), clear (priority over inc),
//        inc (count up by one, holds at all-ones), count.
module cfu_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cfu_cmd_initiator.sv
// Initiator end of the CFU command/response interface.
// Accepts one host request at a time, issues it on the cmd bus, collects the
// response (or aborts on timeout) and holds the result until the host takes it.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_*                 host request (valid/ready, function id, two operands)
//   res_*                 result to host (valid/ready, data, ok, timeout flag)
//   cfu                   CFU bus, master side (cmd_* out, rsp_* in)
//   cmd_count             responses received, saturating
//   timeout_count         timeout aborts, saturating
//   stray_rsp             sticky: response offered while no command accepted
//
// state    | meaning
// IDLE     | ready for a host request
// ISSUE    | cmd_valid high, waiting for cmd_ready
// WAIT_RSP | command accepted, waiting for the response
// DONE     | result held for the host
module cfu_cmd_initiator
    import cfu_if_pkg::*;
#(
    parameter int DWIDTH         = CFU_DWIDTH,
    parameter int AWIDTH         = CFU_AWIDTH,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CWIDTH         = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AWIDTH-1:0] req_function_id,
    input  logic [DWIDTH-1:0] req_inputs_0,
    input  logic [DWIDTH-1:0] req_inputs_1,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [DWIDTH-1:0] res_data,
    output logic              res_ok,
    output logic              res_timeout,

    cfu_cmd_initiator_if.master cfu,

    output logic [CWIDTH-1:0] cmd_count,
    output logic [CWIDTH-1:0] timeout_count,
    output logic              stray_rsp
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST =
        TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    cfu_state_e        state_q, state_d;
    logic              live_q;
    logic              cmd_valid_q, cmd_valid_d;
    logic [AWIDTH-1:0] fid_q, fid_d;
    logic [DWIDTH-1:0] in0_q, in0_d;
    logic [DWIDTH-1:0] in1_q, in1_d;
    logic              res_valid_q, res_valid_d;
    logic [DWIDTH-1:0] res_data_q, res_data_d;
    logic              res_ok_q, res_ok_d;
    logic              res_timeout_q, res_timeout_d;
    logic              stray_q, stray_d;

    logic              cnt_inc, to_inc, tmr_clr, tmr_inc;
    logic [TW-1:0]     timer_q;
    logic              timer_last;
    logic              req_hs, cmd_hs, rsp_hs, res_hs;
    logic              rsp_ready_int;

    // live_q keeps req_ready low for the cycle after reset is sampled, so
    // every output reads 0 while reset is held, yet req_ready still depends
    // on registered state only.
    assign req_ready     = (state_q == IDLE) && live_q;
    assign rsp_ready_int = (state_q == ISSUE) || (state_q == WAIT_RSP);

    assign req_hs = req_valid && req_ready;
    assign cmd_hs = cmd_valid_q && cfu.cmd_ready;
    assign rsp_hs = cfu.rsp_valid && rsp_ready_int;
    assign res_hs = res_valid_q && res_ready;

    assign timer_last = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST);

    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        fid_d         = fid_q;
        in0_d         = in0_q;
        in1_d         = in1_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_ok_d      = res_ok_q;
        res_timeout_d = res_timeout_q;
        stray_d       = stray_q;
        cnt_inc       = 1'b0;
        to_inc        = 1'b0;
        tmr_clr       = 1'b0;
        tmr_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    fid_d       = req_function_id;
                    in0_d       = req_inputs_0;
                    in1_d       = req_inputs_1;
                    cmd_valid_d = 1'b1;
                    tmr_clr     = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                tmr_inc = 1'b1;
                // A response before our command is accepted cannot belong to it.
                if (rsp_hs && !cmd_hs) begin
                    stray_d = 1'b1;
                end
                if (cmd_hs && rsp_hs) begin
                    cmd_valid_d   = 1'b0;
                    res_valid_d   = 1'b1;
                    res_data_d    = cfu.rsp_payload_outputs_0;
                    res_ok_d      = cfu.rsp_payload_response_ok;
                    res_timeout_d = 1'b0;
                    cnt_inc       = 1'b1;
                    state_d       = DONE;
                end else if (timer_last) begin
                    cmd_valid_d   = 1'b0;
                    res_valid_d   = 1'b1;
                    res_data_d    = '0;
                    res_ok_d      = 1'b0;
                    res_timeout_d = 1'b1;
                    to_inc        = 1'b1;
                    state_d       = DONE;
                end else if (cmd_hs) begin
                    cmd_valid_d = 1'b0;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                tmr_inc = 1'b1;
                if (rsp_hs) begin
                    res_valid_d   = 1'b1;
                    res_data_d    = cfu.rsp_payload_outputs_0;
                    res_ok_d      = cfu.rsp_payload_response_ok;
                    res_timeout_d = 1'b0;
                    cnt_inc       = 1'b1;
                    state_d       = DONE;
                end else if (timer_last) begin
                    res_valid_d   = 1'b1;
                    res_data_d    = '0;
                    res_ok_d      = 1'b0;
                    res_timeout_d = 1'b1;
                    to_inc        = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (res_hs) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            live_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            fid_q         <= '0;
            in0_q         <= '0;
            in1_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_ok_q      <= 1'b0;
            res_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            live_q        <= 1'b1;
            cmd_valid_q   <= cmd_valid_d;
            fid_q         <= fid_d;
            in0_q         <= in0_d;
            in1_q         <= in1_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_ok_q      <= res_ok_d;
            res_timeout_q <= res_timeout_d;
            stray_q       <= stray_d;
        end
    end

    cfu_sat_counter #(.W(CWIDTH)) u_cmd_count (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (cnt_inc),
        .count (cmd_count)
    );

    cfu_sat_counter #(.W(CWIDTH)) u_timeout_count (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (to_inc),
        .count (timeout_count)
    );

    cfu_sat_counter #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clr),
        .inc   (tmr_inc),
        .count (timer_q)
    );

    assign cfu.cmd_valid               = cmd_valid_q;
    assign cfu.cmd_payload_function_id = fid_q;
    assign cfu.cmd_payload_inputs_0    = in0_q;
    assign cfu.cmd_payload_inputs_1    = in1_q;
    assign cfu.rsp_ready               = rsp_ready_int;

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_ok      = res_ok_q;
    assign res_timeout = res_timeout_q;
    assign stray_rsp   = stray_q;

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
module tb_cfu_cmd_initiator;
    import cfu_if_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // main DUT (default timeout)
    logic          req_valid, req_ready, res_valid, res_ready, res_ok, res_timeout, stray_rsp;
    logic [AW-1:0] req_function_id;
    logic [DW-1:0] req_inputs_0, req_inputs_1, res_data;
    logic [CW-1:0] cmd_count, timeout_count;

    // timeout DUT
    logic          req2_valid, req2_ready, res2_valid, res2_ready, res2_ok, res2_timeout, stray2;
    logic [AW-1:0] req2_function_id;
    logic [DW-1:0] req2_inputs_0, req2_inputs_1, res2_data;
    logic [CW-1:0] cmd2_count, timeout2_count;

    // responder controls
    logic          zl_mode;
    logic [DW-1:0] zl_data;
    logic          m_cmd_ready, m_rsp_valid, m_rsp_ok;
    logic [DW-1:0] m_rsp_data;

    cfu_cmd_initiator_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
    cfu_cmd_initiator_if #(.DWIDTH(DW), .AWIDTH(AW)) bus2 ();

    assign bus.cmd_ready               = zl_mode ? bus.rsp_ready : m_cmd_ready;
    assign bus.rsp_valid               = zl_mode ? bus.cmd_valid : m_rsp_valid;
    assign bus.rsp_payload_response_ok = zl_mode ? 1'b1 : m_rsp_ok;
    assign bus.rsp_payload_outputs_0   = zl_mode ? zl_data : m_rsp_data;

    assign bus2.cmd_ready               = 1'b0;
    assign bus2.rsp_valid               = 1'b0;
    assign bus2.rsp_payload_response_ok = 1'b0;
    assign bus2.rsp_payload_outputs_0   = '0;

    cfu_cmd_initiator #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT_CYCLES(256), .CWIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_function_id(req_function_id),
        .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ok(res_ok), .res_timeout(res_timeout),
        .cfu(bus),
        .cmd_count(cmd_count), .timeout_count(timeout_count), .stray_rsp(stray_rsp)
    );

    cfu_cmd_initiator #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT_CYCLES(8), .CWIDTH(CW)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(req2_valid), .req_ready(req2_ready), .req_function_id(req2_function_id),
        .req_inputs_0(req2_inputs_0), .req_inputs_1(req2_inputs_1),
        .res_valid(res2_valid), .res_ready(res2_ready), .res_data(res2_data),
        .res_ok(res2_ok), .res_timeout(res2_timeout),
        .cfu(bus2),
        .cmd_count(cmd2_count), .timeout_count(timeout2_count), .stray_rsp(stray2)
    );

    logic       sc_clear, sc_inc;
    logic [2:0] sc_count;
    cfu_sat_counter #(.W(3)) u_sc (
        .clk(clk), .reset(reset), .clear(sc_clear), .inc(sc_inc), .count(sc_count)
    );

    int cmd_hs_cnt = 0;
    always @(posedge clk) begin
        if (!reset && bus.cmd_valid && bus.cmd_ready) cmd_hs_cnt <= cmd_hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({req_ready, bus.rsp_ready, bus.cmd_valid, res_valid, res_ok, res_timeout, stray_rsp} !== 7'b0)
            $display("FAIL reset_flags got %b exp 0000000",
                     {req_ready, bus.rsp_ready, bus.cmd_valid, res_valid, res_ok, res_timeout, stray_rsp});
        else passed++;
        total++;
        if ({res_data, bus.cmd_payload_function_id, bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1,
             cmd_count, timeout_count} !== '0)
            $display("FAIL reset_data got res_data=%h fid=%h in0=%h in1=%h cc=%0d tc=%0d exp all 0",
                     res_data, bus.cmd_payload_function_id, bus.cmd_payload_inputs_0,
                     bus.cmd_payload_inputs_1, cmd_count, timeout_count);
        else passed++;
        reset = 1'b0;
        tick();
        total++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_req_ready got %b exp 1", req_ready);
        else passed++;
    endtask

    task automatic test_zero_latency();
        zl_mode = 1'b1;
        zl_data = 32'hA5A5_0001;
        req_valid = 1'b1;
        req_function_id = make_function_id(1'b1, 1'b0, 8'h00);
        req_inputs_0 = 32'h0000_00AA;
        req_inputs_1 = 32'h0000_00BB;
        tick();
        req_valid = 1'b0;
        total++;
        if ({bus.cmd_valid, res_valid, bus.cmd_payload_function_id} !== {1'b1, 1'b0, 10'h001})
            $display("FAIL zl_issue got cmd_valid=%b res_valid=%b fid=%h exp 1 0 001",
                     bus.cmd_valid, res_valid, bus.cmd_payload_function_id);
        else passed++;
        tick();
        total++;
        if ({res_valid, res_ok, res_timeout, bus.cmd_valid} !== 4'b1100)
            $display("FAIL zl_done_flags got %b exp 1100", {res_valid, res_ok, res_timeout, bus.cmd_valid});
        else passed++;
        total++;
        if (res_data !== 32'hA5A5_0001) $display("FAIL zl_res_data got %h exp a5a50001", res_data);
        else passed++;
        total++;
        if (cmd_count !== 16'd1) $display("FAIL zl_cmd_count got %0d exp 1", cmd_count);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        zl_mode = 1'b0;
        total++;
        if ({res_valid, req_ready} !== 2'b01)
            $display("FAIL zl_consume got res_valid=%b req_ready=%b exp 0 1", res_valid, req_ready);
        else passed++;
    endtask

    task automatic test_cmd_stall();
        int hs0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        hs0 = cmd_hs_cnt;
        req_valid = 1'b1;
        req_function_id = 10'h002;
        req_inputs_0 = 32'h0000_1111;
        req_inputs_1 = 32'h0000_2222;
        tick();
        req_valid = 1'b0;
        req_function_id = 10'h3FF;
        req_inputs_0 = 32'hFFFF_FFFF;
        req_inputs_1 = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({bus.cmd_valid, bus.cmd_payload_function_id, bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1}
                !== {1'b1, 10'h002, 32'h0000_1111, 32'h0000_2222})
                $display("FAIL stall_payload_%0d got v=%b fid=%h in0=%h in1=%h exp 1 002 00001111 00002222",
                         i, bus.cmd_valid, bus.cmd_payload_function_id,
                         bus.cmd_payload_inputs_0, bus.cmd_payload_inputs_1);
            else passed++;
            tick();
        end
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        total++;
        if ({bus.cmd_valid, bus.rsp_ready, res_valid} !== 3'b010)
            $display("FAIL stall_wait got cmd_valid=%b rsp_ready=%b res_valid=%b exp 0 1 0",
                     bus.cmd_valid, bus.rsp_ready, res_valid);
        else passed++;
        tick();
        tick();
        total++;
        if (res_valid !== 1'b0) $display("FAIL stall_early_res got %b exp 0", res_valid);
        else passed++;
        m_rsp_valid = 1'b1;
        m_rsp_ok = 1'b1;
        m_rsp_data = 32'h1234_5678;
        tick();
        m_rsp_valid = 1'b0;
        total++;
        if ({res_valid, res_ok, res_timeout, res_data} !== {3'b110, 32'h1234_5678})
            $display("FAIL stall_result got v=%b ok=%b to=%b data=%h exp 1 1 0 12345678",
                     res_valid, res_ok, res_timeout, res_data);
        else passed++;
        total++;
        if (cmd_hs_cnt - hs0 !== 1) $display("FAIL stall_cmd_handshakes got %0d exp 1", cmd_hs_cnt - hs0);
        else passed++;
        total++;
        if (cmd_count !== 16'd2) $display("FAIL stall_cmd_count got %0d exp 2", cmd_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        // result from the previous test is still pending
        req_valid = 1'b1;
        req_function_id = 10'h003;
        req_inputs_0 = 32'h0000_0033;
        req_inputs_1 = 32'h0000_0044;
        res_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({res_valid, req_ready, res_data} !== {2'b10, 32'h1234_5678})
                $display("FAIL b2b_hold_%0d got res_valid=%b req_ready=%b data=%h exp 1 0 12345678",
                         i, res_valid, req_ready, res_data);
            else passed++;
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if ({res_valid, req_ready, bus.cmd_valid} !== 3'b010)
            $display("FAIL b2b_after_consume got res_valid=%b req_ready=%b cmd_valid=%b exp 0 1 0",
                     res_valid, req_ready, bus.cmd_valid);
        else passed++;
        tick();
        req_valid = 1'b0;
        total++;
        if ({bus.cmd_valid, bus.cmd_payload_function_id} !== {1'b1, 10'h003})
            $display("FAIL b2b_second_issue got cmd_valid=%b fid=%h exp 1 003",
                     bus.cmd_valid, bus.cmd_payload_function_id);
        else passed++;
        m_cmd_ready = 1'b1;
        m_rsp_valid = 1'b1;
        m_rsp_ok = 1'b1;
        m_rsp_data = 32'hCAFE_0003;
        tick();
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b0;
        total++;
        if ({res_valid, res_data, cmd_count} !== {1'b1, 32'hCAFE_0003, 16'd3})
            $display("FAIL b2b_second_result got v=%b data=%h cc=%0d exp 1 cafe0003 3",
                     res_valid, res_data, cmd_count);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1;
        req_function_id = 10'h004;
        req_inputs_0 = 32'h0000_0055;
        req_inputs_1 = 32'h0000_0066;
        tick();
        req_valid = 1'b0;
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        total++;
        if ({bus.cmd_valid, bus.rsp_ready} !== 2'b01)
            $display("FAIL rst_mid_in_wait got cmd_valid=%b rsp_ready=%b exp 0 1", bus.cmd_valid, bus.rsp_ready);
        else passed++;
        reset = 1'b1;
        m_rsp_valid = 1'b1;
        m_rsp_ok = 1'b1;
        m_rsp_data = 32'hDEAD_BEEF;
        tick();
        total++;
        if ({req_ready, bus.rsp_ready, bus.cmd_valid, res_valid, res_ok, res_timeout, stray_rsp} !== 7'b0
            || {res_data, bus.cmd_payload_function_id, cmd_count, timeout_count} !== '0)
            $display("FAIL rst_mid_outputs got rr=%b rspr=%b cv=%b rv=%b data=%h fid=%h cc=%0d exp all 0",
                     req_ready, bus.rsp_ready, bus.cmd_valid, res_valid, res_data,
                     bus.cmd_payload_function_id, cmd_count);
        else passed++;
        reset = 1'b0;
        tick();
        m_rsp_valid = 1'b0;
        total++;
        if ({res_valid, bus.rsp_ready, req_ready, stray_rsp, cmd_count} !== {4'b0010, 16'd0})
            $display("FAIL rst_mid_ignore got rv=%b rspr=%b rr=%b stray=%b cc=%0d exp 0 0 1 0 0",
                     res_valid, bus.rsp_ready, req_ready, stray_rsp, cmd_count);
        else passed++;
    endtask

    task automatic test_stray();
        req_valid = 1'b1;
        req_function_id = 10'h005;
        req_inputs_0 = 32'h0000_0077;
        req_inputs_1 = 32'h0000_0088;
        tick();
        req_valid = 1'b0;
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_ok = 1'b1;
        m_rsp_data = 32'hBAD0_BAD0;
        tick();
        m_rsp_valid = 1'b0;
        total++;
        if ({stray_rsp, bus.cmd_valid, res_valid} !== 3'b110)
            $display("FAIL stray_set got stray=%b cmd_valid=%b res_valid=%b exp 1 1 0",
                     stray_rsp, bus.cmd_valid, res_valid);
        else passed++;
        tick();
        m_cmd_ready = 1'b1;
        tick();
        m_cmd_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_ok = 1'b0;
        m_rsp_data = 32'h0000_55AA;
        tick();
        m_rsp_valid = 1'b0;
        total++;
        if ({res_valid, res_ok, res_timeout, res_data, cmd_count, stray_rsp}
            !== {3'b100, 32'h0000_55AA, 16'd1, 1'b1})
            $display("FAIL stray_complete got v=%b ok=%b to=%b data=%h cc=%0d stray=%b exp 1 0 0 000055aa 1 1",
                     res_valid, res_ok, res_timeout, res_data, cmd_count, stray_rsp);
        else passed++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        total++;
        if (stray_rsp !== 1'b1) $display("FAIL stray_sticky got %b exp 1", stray_rsp);
        else passed++;
    endtask

    task automatic test_timeout();
        int n;
        req2_valid = 1'b1;
        req2_function_id = 10'h006;
        req2_inputs_0 = 32'h1;
        req2_inputs_1 = 32'h2;
        tick();
        req2_valid = 1'b0;
        n = 0;
        while (bus2.cmd_valid === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++;
        if (n !== 8) $display("FAIL timeout_cmd_valid_cycles got %0d exp 8", n);
        else passed++;
        total++;
        if ({res2_valid, res2_timeout, res2_ok, res2_data} !== {3'b110, 32'h0})
            $display("FAIL timeout_result got v=%b to=%b ok=%b data=%h exp 1 1 0 00000000",
                     res2_valid, res2_timeout, res2_ok, res2_data);
        else passed++;
        total++;
        if ({timeout2_count, cmd2_count} !== {16'd1, 16'd0})
            $display("FAIL timeout_counts got tc=%0d cc=%0d exp 1 0", timeout2_count, cmd2_count);
        else passed++;
        res2_ready = 1'b1;
        tick();
        res2_ready = 1'b0;
        total++;
        if ({res2_valid, req2_ready} !== 2'b01)
            $display("FAIL timeout_consume got res_valid=%b req_ready=%b exp 0 1", res2_valid, req2_ready);
        else passed++;
    endtask

    task automatic test_saturation();
        sc_clear = 1'b0;
        sc_inc = 1'b1;
        repeat (5) tick();
        total++;
        if (sc_count !== 3'd5) $display("FAIL sat_count_5 got %0d exp 5", sc_count);
        else passed++;
        repeat (5) tick();
        total++;
        if (sc_count !== 3'd7) $display("FAIL sat_hold got %0d exp 7", sc_count);
        else passed++;
        sc_inc = 1'b0;
        sc_clear = 1'b1;
        tick();
        sc_clear = 1'b0;
        total++;
        if (sc_count !== 3'd0) $display("FAIL sat_clear got %0d exp 0", sc_count);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_function_id = '0; req_inputs_0 = '0; req_inputs_1 = '0; res_ready = 1'b0;
        req2_valid = 1'b0; req2_function_id = '0; req2_inputs_0 = '0; req2_inputs_1 = '0; res2_ready = 1'b0;
        zl_mode = 1'b0; zl_data = '0;
        m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_ok = 1'b0; m_rsp_data = '0;
        sc_clear = 1'b0; sc_inc = 1'b0;
        #2;
        test_reset();
        test_zero_latency();
        test_cmd_stall();
        test_back_to_back();
        test_reset_mid_wait();
        test_stray();
        test_timeout();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cfu_cmd_initiator.md
Name: cfu_cmd_initiator

Overview:
- Initiator (CPU-side) end of the CFU command/response interface: takes host requests, drives cmd_* to a CFU responder such as the PIM CFU, collects rsp_*, returns results to the host.
- Used as a standalone bench/driver and as the bridge from a host sequencer into the PIM CFU.
- One command outstanding at a time, with a result holding register, a response timeout and status counters.

Parameters:
- DWIDTH, 32, width of inputs_0/1, outputs_0 and res_data.
- AWIDTH, 10, width of function_id.
- TIMEOUT_CYCLES, 256, max cycles from first cmd_valid to rsp handshake; 0 disables the timeout.
- CWIDTH, 16, width of status counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  host request accepted when req_valid&&req_ready.
- req_function_id  in  AWIDTH  function id to issue.
- req_inputs_0  in  DWIDTH  operand 0.
- req_inputs_1  in  DWIDTH  operand 1.
- res_valid  out  1  result available.
- res_ready  in  1  host consumes result.
- res_data  out  DWIDTH  captured rsp_payload_outputs_0.
- res_ok  out  1  captured rsp_payload_response_ok.
- res_timeout  out  1  result is a timeout abort.
- cmd_valid  out  1  command valid to CFU.
- cmd_ready  in  1  CFU accepts command.
- cmd_payload_function_id  out  AWIDTH  registered function id.
- cmd_payload_inputs_0  out  DWIDTH  registered operand 0.
- cmd_payload_inputs_1  out  DWIDTH  registered operand 1.
- rsp_valid  in  1  CFU response valid.
- rsp_ready  out  1  initiator accepts response.
- rsp_payload_response_ok  in  1  response status.
- rsp_payload_outputs_0  in  DWIDTH  response data.
- cmd_count  out  CWIDTH  commands completed with a response, saturating.
- timeout_count  out  CWIDTH  timeouts, saturating.
- stray_rsp  out  1  sticky flag: response seen with no command accepted.

Behaviour:
- Reset, synchronous and active-high, takes priority over everything including mid-transaction.
  - State goes to IDLE.
  - All outputs go to 0: req_ready, res_valid, res_data, res_ok, res_timeout, cmd_valid, all cmd_payload_*, rsp_ready, both counters, stray_rsp.
- Handshakes: a transfer occurs on any clk edge where valid&&ready. All outputs are registered except req_ready and rsp_ready, which are decoded from the state register only, never from any input.
- States:
  - IDLE:
    - req_ready=1.
    - On a req handshake, latch id/inputs into cmd_payload_*, set cmd_valid=1, go to ISSUE.
    - The latched payload then first appears on the cmd bus the cycle after the req handshake.
  - ISSUE:
    - cmd_valid=1 and rsp_ready=1 (needed for responders with cmd_ready tied to rsp_ready).
    - Payload is held stable until cmd handshake or timeout.
    - cmd and rsp handshakes in the same cycle: capture the response, cmd_valid<=0, go to DONE (zero-latency responder).
    - cmd handshake only: cmd_valid<=0, go to WAIT_RSP.
    - rsp handshake without a cmd handshake: discard it, set stray_rsp, stay in ISSUE.
  - WAIT_RSP:
    - rsp_ready=1.
    - On an rsp handshake: capture res_data<=rsp_payload_outputs_0, res_ok<=rsp_payload_response_ok, res_timeout<=0, increment cmd_count, go to DONE.
  - DONE:
    - res_valid=1; result held stable until res_ready.
    - On a res handshake: res_valid<=0, go to IDLE.
    - req_ready=0 in DONE, so the next request is accepted the cycle after the result is consumed.
- Timeout:
  - The counter clears on ISSUE entry and increments every cycle in ISSUE or WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES and no rsp handshake occurs that cycle:
    - cmd_valid<=0 (this is the only case where cmd_valid drops without cmd_ready);
    - res_data<=0, res_ok<=0, res_timeout<=1;
    - increment timeout_count; go to DONE.
  - An rsp handshake in the same cycle as expiry wins; it is not a timeout.
  - A late response arriving in DONE/IDLE is not accepted (rsp_ready=0 there) and sets stray_rsp only if rsp_valid&&!cmd_valid in ISSUE.
- Latency:
  - Min req handshake to res_valid is 2 cycles with a zero-latency responder (1 to ISSUE, 1 to DONE).
  - Otherwise add the responder cmd_ready wait plus response latency.
- Counters saturate at all-ones and never wrap.
- stray_rsp clears only on reset.

Decomposition:
- Shared package cfu_if_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RSP, DONE);
  - default DWIDTH/AWIDTH constants, shared with the CFU responder;
  - the function_id bit positions used by the PIM CFU (bit0 write, bit1 process, top 8 bits address), so the host/bench can build ids.
- One natural sub-module: cfu_sat_counter (saturating CWIDTH counter, inc/clear), instantiated for cmd_count, timeout_count and the timeout timer.

Test Plan:
- Zero-latency responder (rsp_valid=cmd_valid, cmd_ready=rsp_ready, data=0xA5A5_0001): request id=0x001 -> res_valid 2 cycles after req handshake, res_data=0xA5A5_0001, res_ok=1, cmd_count=1.
- Responder holds cmd_ready=0 for 5 cycles, then responds 3 cycles after accept with 0x1234_5678 -> payload stable all 5 cycles, single cmd handshake, res_data=0x1234_5678.
- res_ready held low 10 cycles with a second req pending -> res_data unchanged, req_ready=0 throughout; second request is accepted the cycle after res handshake.
- TIMEOUT_CYCLES=8, responder never answers -> cmd_valid drops on cycle 8, res_timeout=1, res_data=0, res_ok=0, timeout_count=1, cmd_count=0.
- Reset asserted in WAIT_RSP, then response arrives -> all outputs 0 next cycle, state IDLE, response ignored (rsp_ready=0), counters 0.
- rsp_valid pulsed in ISSUE while cmd_ready=0 -> stray_rsp=1 sticky; the command still completes normally afterward.
